bypass_source: RTL and testbench
================================

Name: bypass_source

Overview:
- Producer side of the EX-stage operand bypass: registers each retiring ALU result with its destination register, holds a two-deep history (EX/MEM slot S1, MEM/WB slot S2), and drives the forwarded operands consumed by the next instruction.
- Qualifies flag-only ALU ops (TST/TEQ/CMP/CMN) as non-writing, so no stale result is ever forwarded.
- Sits between the ALU output and the operand muxes in front of the ALU; S2 also drives the register-file write port.

Parameters:
- DW, 32, datapath width.
- REGAW, `REGAW (4), register address width.
- ALUAW, `ALUAW, ALU opcode width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  hold S1/S2 contents.
- flush  in  1  squash the instruction currently presented at EX.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_alu_opcode  in  ALUAW  opcode of the EX instruction.
- ex_wb_en  in  1  EX instruction requests a register write.
- ex_rd  in  REGAW  EX destination register.
- ex_result  in  DW  ALU result.
- rs_a, rs_b  in  REGAW  source registers of the instruction entering EX.
- rf_a, rf_b  in  DW  register-file read data for rs_a/rs_b.
- op_a, op_b  out  DW  bypassed operands.
- fwd_a_sel, fwd_b_sel  out  2  source select: 0 = regfile, 1 = S1, 2 = S2.
- wb_en  out  1  register-file write enable (S2 valid and writing).
- wb_rd  out  REGAW  write address.
- wb_data  out  DW  write data.

Behaviour:
- Slot contents: valid, wr, rd, data.
- Captured write qualifier: wr = ex_valid & ex_wb_en & (ex_alu_opcode not in {TST, TEQ, CMP, CMN}).
- On every posedge clk, in priority order:
  - rst: S1.valid = S2.valid = 0, S1/S2 wr/rd/data = 0.
  - flush: S1 loads a bubble (valid = 0, wr = 0); S2 = S1. Flush overrides a simultaneous stall, because the older S1 instruction must still commit.
  - stall: S1 and S2 hold; the EX inputs are ignored.
  - otherwise: S2 = S1; S1 = {ex_valid, wr, ex_rd, ex_result}.
- Latency: a result presented at EX in cycle N is forwardable from S1 in cycle N+1 and from S2 in cycle N+2. wb_en pulses in cycle N+2, absent stalls.
- Match condition, per operand x ∈ {a, b}: hit1 = S1.valid & S1.wr & (S1.rd == rs_x); hit2 = S2.valid & S2.wr & (S2.rd == rs_x).
- Priority: hit1 selects S1 (sel = 1), else hit2 selects S2 (sel = 2), else rf_x (sel = 0). The youngest writer always wins when S1 and S2 hold the same rd.
- rs_x == 4'hF (PC) never forwards: sel = 0, op = rf_x.
- Operand outputs are combinational from slot registers and rs/rf inputs; there is no path from ex_* to op_*.
- wb_en = S2.valid & S2.wr; wb_rd = S2.rd; wb_data = S2.data.
- Reset values of outputs:
  - wb_en = 0, wb_rd = 0, wb_data = 0.
  - fwd_*_sel = 0 and op_* = rf_* (no slot valid).
- Reset asserted mid-stall or mid-flush: reset wins; the next cycle starts empty.
- During stall, the forwarding outputs still track rs/rf changes against the held slots.
- Exactly one writer per cycle; there is no write/read collision inside the block. Regfile write-before-read ordering is the regfile's responsibility.

Decomposition:
- Shared defines (defines.v): `ALUAW, `REGAW, and opcode constants `TST, `TEQ, `CMP, `CMN.
- Add `BYP_RF = 2'd0, `BYP_S1 = 2'd1, `BYP_S2 = 2'd2 to defines.v for the select encoding.
- One natural sub-module, bypass_match: a combinational per-operand comparator and mux taking S1/S2 state, rs, and rf, producing sel and op. Instantiate it twice, for a and b.

Test Plan:
- Back-to-back dependency:
  - Stimulus: cycle 0 EX ADD r3 = 0x0000_0011 (ex_wb_en = 1); cycle 1 rs_a = 3, rf_a = 0xDEAD_BEEF.
  - Required: fwd_a_sel = 1, op_a = 0x11.
  - Cycle 2, no new writer: sel = 2, op_a = 0x11, wb_en = 1, wb_rd = 3, wb_data = 0x11.
- Flag-only op:
  - Stimulus: CMP with ex_rd = 3, result 0x5; next cycle rs_a = 3, rf_a = 0x7.
  - Required: sel = 0, op_a = 0x7; two cycles later wb_en = 0.
- Priority:
  - Stimulus: r2 = 0xA then r2 = 0xB on consecutive cycles; next cycle rs_a = rs_b = 2.
  - Required: op_a = op_b = 0xB, sel = 1 on both.
- PC guard:
  - Stimulus: write r15 = 0x100; next cycle rs_a = 15, rf_a = 0x200.
  - Required: op_a = 0x200, sel = 0.
- Stall/flush:
  - Stimulus: S1 = r4:0x44, stall = 1 for 3 cycles with new ex_* values.
  - Required: S1 and S2 unchanged, op for r4 = 0x44 throughout.
  - Then flush = 1 and stall = 1 together: next cycle S1 is a bubble, S2 holds r4:0x44, wb_en = 1.
- Reset:
  - Stimulus: assert rst with S1/S2 full.
  - Required: next cycle wb_en = 0, all sel = 0, op_* = rf_*.

Source files
------------

// File: rtl/bypass_source_pkg.sv
// Shared widths, ALU opcode constants and forward-select encoding for the
// EX-stage operand bypass.
package bypass_source_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_REGAW = 4;
    localparam int DEF_ALUAW = 4;

    localparam logic [DEF_ALUAW-1:0] OP_TST = 4'h8;
    localparam logic [DEF_ALUAW-1:0] OP_TEQ = 4'h9;
    localparam logic [DEF_ALUAW-1:0] OP_CMP = 4'hA;
    localparam logic [DEF_ALUAW-1:0] OP_CMN = 4'hB;

    localparam logic [1:0] BYP_RF = 2'd0;
    localparam logic [1:0] BYP_S1 = 2'd1;
    localparam logic [1:0] BYP_S2 = 2'd2;

    // Flag-setting compares leave the destination register untouched.
    function automatic logic is_flag_only(input logic [DEF_ALUAW-1:0] opcode);
        return (opcode == OP_TST) || (opcode == OP_TEQ) ||
               (opcode == OP_CMP) || (opcode == OP_CMN);
    endfunction

endpackage

// File: rtl/bypass_match.sv
// Per-operand bypass comparator and mux: picks the youngest in-flight writer
// of rs, falling back to register-file data.
module bypass_match
    import bypass_source_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int REGAW = DEF_REGAW
) (
    input  logic             s1_vld,
    input  logic             s1_wr,
    input  logic [REGAW-1:0] s1_rd,
    input  logic [DW-1:0]    s1_data,
    input  logic             s2_vld,
    input  logic             s2_wr,
    input  logic [REGAW-1:0] s2_rd,
    input  logic [DW-1:0]    s2_data,
    input  logic [REGAW-1:0] rs,
    input  logic [DW-1:0]    rf,
    output logic [1:0]       sel,
    output logic [DW-1:0]    op
);

    logic hit1;
    logic hit2;
    logic is_pc;

    assign hit1  = s1_vld && s1_wr && (s1_rd == rs);
    assign hit2  = s2_vld && s2_wr && (s2_rd == rs);
    // The PC is read fresh from the register file and is never forwarded.
    assign is_pc = (rs == {REGAW{1'b1}});

    always_comb begin
        sel = BYP_RF;
        op  = rf;
        if (!is_pc) begin
            if (hit1) begin
                sel = BYP_S1;
                op  = s1_data;
            end else if (hit2) begin
                sel = BYP_S2;
                op  = s2_data;
            end
        end
    end

endmodule

// File: rtl/bypass_source.sv
// Producer side of the EX operand bypass: two-deep result history (S1 = EX/MEM,
// S2 = MEM/WB) feeding the operand muxes and the register-file write port.
module bypass_source
    import bypass_source_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int REGAW = DEF_REGAW,
    parameter int ALUAW = DEF_ALUAW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [ALUAW-1:0] ex_alu_opcode,
    input  logic             ex_wb_en,
    input  logic [REGAW-1:0] ex_rd,
    input  logic [DW-1:0]    ex_result,
    input  logic [REGAW-1:0] rs_a,
    input  logic [REGAW-1:0] rs_b,
    input  logic [DW-1:0]    rf_a,
    input  logic [DW-1:0]    rf_b,
    output logic [DW-1:0]    op_a,
    output logic [DW-1:0]    op_b,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             wb_en,
    output logic [REGAW-1:0] wb_rd,
    output logic [DW-1:0]    wb_data
);

    logic             ex_wr;

    logic             s1_vld_p1;
    logic             s1_wr_p1;
    logic [REGAW-1:0] s1_rd_p1;
    logic [DW-1:0]    s1_data_p1;

    logic             s2_vld_p2;
    logic             s2_wr_p2;
    logic [REGAW-1:0] s2_rd_p2;
    logic [DW-1:0]    s2_data_p2;

    assign ex_wr = ex_valid && ex_wb_en && !is_flag_only(ex_alu_opcode);

    // EX -> S1 -> S2; flush still retires S1 into S2 even when stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_p1  <= 1'b0;
            s1_wr_p1   <= 1'b0;
            s1_rd_p1   <= '0;
            s1_data_p1 <= '0;
            s2_vld_p2  <= 1'b0;
            s2_wr_p2   <= 1'b0;
            s2_rd_p2   <= '0;
            s2_data_p2 <= '0;
        end else if (flush) begin
            s2_vld_p2  <= s1_vld_p1;
            s2_wr_p2   <= s1_wr_p1;
            s2_rd_p2   <= s1_rd_p1;
            s2_data_p2 <= s1_data_p1;
            s1_vld_p1  <= 1'b0;
            s1_wr_p1   <= 1'b0;
        end else if (!stall) begin
            s2_vld_p2  <= s1_vld_p1;
            s2_wr_p2   <= s1_wr_p1;
            s2_rd_p2   <= s1_rd_p1;
            s2_data_p2 <= s1_data_p1;
            s1_vld_p1  <= ex_valid;
            s1_wr_p1   <= ex_wr;
            s1_rd_p1   <= ex_rd;
            s1_data_p1 <= ex_result;
        end
    end

    // Operand selection: combinational from slot registers only.
    bypass_match #(.DW(DW), .REGAW(REGAW)) u_match_a (
        .s1_vld  (s1_vld_p1),
        .s1_wr   (s1_wr_p1),
        .s1_rd   (s1_rd_p1),
        .s1_data (s1_data_p1),
        .s2_vld  (s2_vld_p2),
        .s2_wr   (s2_wr_p2),
        .s2_rd   (s2_rd_p2),
        .s2_data (s2_data_p2),
        .rs      (rs_a),
        .rf      (rf_a),
        .sel     (fwd_a_sel),
        .op      (op_a)
    );

    bypass_match #(.DW(DW), .REGAW(REGAW)) u_match_b (
        .s1_vld  (s1_vld_p1),
        .s1_wr   (s1_wr_p1),
        .s1_rd   (s1_rd_p1),
        .s1_data (s1_data_p1),
        .s2_vld  (s2_vld_p2),
        .s2_wr   (s2_wr_p2),
        .s2_rd   (s2_rd_p2),
        .s2_data (s2_data_p2),
        .rs      (rs_b),
        .rf      (rf_b),
        .sel     (fwd_b_sel),
        .op      (op_b)
    );

    assign wb_en   = s2_vld_p2 && s2_wr_p2;
    assign wb_rd   = s2_rd_p2;
    assign wb_data = s2_data_p2;

endmodule

// File: tb/tb_bypass_source.sv
// Self-checking bench for bypass_source: directed forwarding checks plus a
// write-back scoreboard fed at issue time and drained from wb_en.
module tb_bypass_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_alu_opcode;
    logic        ex_wb_en;
    logic [3:0]  ex_rd;
    logic [31:0] ex_result;
    logic [3:0]  rs_a;
    logic [3:0]  rs_b;
    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;
    logic [35:0] wb_q[$];

    localparam logic [3:0] ADD = 4'h4;
    localparam logic [3:0] CMP = 4'hA;

    always #5 clk = ~clk;

    bypass_source dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_alu_opcode (ex_alu_opcode),
        .ex_wb_en      (ex_wb_en),
        .ex_rd         (ex_rd),
        .ex_result     (ex_result),
        .rs_a          (rs_a),
        .rs_b          (rs_b),
        .rf_a          (rf_a),
        .rf_b          (rf_b),
        .op_a          (op_a),
        .op_b          (op_b),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive the EX instruction; if it will actually commit, expect its write-back.
    task automatic drive_ex(input logic v, input logic [3:0] opc, input logic we,
                            input logic [3:0] rd, input logic [31:0] res);
        logic writes;
        ex_valid      = v;
        ex_alu_opcode = opc;
        ex_wb_en      = we;
        ex_rd         = rd;
        ex_result     = res;
        writes = v && we && !(opc inside {4'h8, 4'h9, 4'hA, 4'hB});
        if (writes && !stall && !flush && !rst) wb_q.push_back({rd, res});
    endtask

    task automatic idle();
        drive_ex(1'b0, ADD, 1'b0, 4'd0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && wb_en) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", {28'h0, wb_rd}, 32'hFFFF_FFFF);
            end else begin
                logic [35:0] e;
                e = wb_q.pop_front();
                check("wb_sb_rd", {28'h0, wb_rd}, {28'h0, e[35:32]});
                check("wb_sb_data", wb_data, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        rs_a = 4'd1; rs_b = 4'd2; rf_a = 32'h1234; rf_b = 32'h5678;
        idle();
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_wb_en", {31'h0, wb_en}, 32'h0);
        check("rst_wb_rd", {28'h0, wb_rd}, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_sel_a", {30'h0, fwd_a_sel}, 32'h0);
        check("rst_op_b", op_b, 32'h5678);

        // Back-to-back dependency
        drive_ex(1'b1, ADD, 1'b1, 4'd3, 32'h11);
        step();
        idle();
        rs_a = 4'd3; rf_a = 32'hDEAD_BEEF;
        #1;
        check("b2b_sel_s1", {30'h0, fwd_a_sel}, 32'd1);
        check("b2b_op_s1", op_a, 32'h11);
        step();
        check("b2b_sel_s2", {30'h0, fwd_a_sel}, 32'd2);
        check("b2b_op_s2", op_a, 32'h11);
        check("b2b_wb_en", {31'h0, wb_en}, 32'h1);
        check("b2b_wb_rd", {28'h0, wb_rd}, 32'd3);
        check("b2b_wb_data", wb_data, 32'h11);
        step();

        // Flag-only op never forwards nor writes
        drive_ex(1'b1, CMP, 1'b1, 4'd3, 32'h5);
        step();
        idle();
        rs_a = 4'd3; rf_a = 32'h7;
        #1;
        check("cmp_sel", {30'h0, fwd_a_sel}, 32'd0);
        check("cmp_op", op_a, 32'h7);
        step();
        check("cmp_wb_en", {31'h0, wb_en}, 32'h0);
        check("cmp_sel_s2", {30'h0, fwd_a_sel}, 32'd0);
        step();

        // Youngest writer wins
        drive_ex(1'b1, ADD, 1'b1, 4'd2, 32'hA);
        step();
        drive_ex(1'b1, ADD, 1'b1, 4'd2, 32'hB);
        step();
        idle();
        rs_a = 4'd2; rs_b = 4'd2; rf_a = 32'h0; rf_b = 32'h0;
        #1;
        check("pri_op_a", op_a, 32'hB);
        check("pri_op_b", op_b, 32'hB);
        check("pri_sel_a", {30'h0, fwd_a_sel}, 32'd1);
        check("pri_sel_b", {30'h0, fwd_b_sel}, 32'd1);
        step();
        check("pri_s2_sel", {30'h0, fwd_b_sel}, 32'd2);
        check("pri_s2_op", op_b, 32'hB);
        step();

        // PC guard
        drive_ex(1'b1, ADD, 1'b1, 4'd15, 32'h100);
        step();
        idle();
        rs_a = 4'd15; rf_a = 32'h200;
        #1;
        check("pc_op", op_a, 32'h200);
        check("pc_sel", {30'h0, fwd_a_sel}, 32'd0);
        step(); step();

        // Stall holds the slots; EX inputs are ignored
        drive_ex(1'b1, ADD, 1'b1, 4'd4, 32'h44);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, ADD, 1'b1, 4'd4, 32'h99 + i);
            rs_a = 4'd4; rf_a = 32'h1000 + i;
            rs_b = (i == 1) ? 4'd4 : 4'd6; rf_b = 32'h2000 + i;
            #1;
            check("stall_sel_a", {30'h0, fwd_a_sel}, 32'd1);
            check("stall_op_a", op_a, 32'h44);
            check("stall_op_b", op_b, (i == 1) ? 32'h44 : 32'h2000 + i);
            check("stall_wb_en", {31'h0, wb_en}, 32'h0);
            step();
        end
        // Flush with stall: S1 retires, EX instruction squashed
        flush = 1'b1;
        drive_ex(1'b1, ADD, 1'b1, 4'd5, 32'h55);
        step();
        flush = 1'b0; stall = 1'b0;
        idle();
        rs_a = 4'd4; rs_b = 4'd5; rf_b = 32'h3;
        #1;
        check("flush_sel_a", {30'h0, fwd_a_sel}, 32'd2);
        check("flush_op_a", op_a, 32'h44);
        check("flush_op_b", op_b, 32'h3);
        check("flush_wb_en", {31'h0, wb_en}, 32'h1);
        check("flush_wb_rd", {28'h0, wb_rd}, 32'd4);
        check("flush_wb_data", wb_data, 32'h44);
        step(); step();

        // Reset with both slots full, during a stall
        drive_ex(1'b1, ADD, 1'b1, 4'd6, 32'h66);
        step();
        drive_ex(1'b1, ADD, 1'b1, 4'd7, 32'h77);
        step();
        idle();
        rst = 1'b1; stall = 1'b1;
        @(negedge clk);
        #1;
        wb_q.delete();
        step();
        rst = 1'b0; stall = 1'b0;
        rs_a = 4'd7; rf_a = 32'h1; rs_b = 4'd6; rf_b = 32'h2;
        #1;
        check("rst2_wb_en", {31'h0, wb_en}, 32'h0);
        check("rst2_sel_a", {30'h0, fwd_a_sel}, 32'd0);
        check("rst2_sel_b", {30'h0, fwd_b_sel}, 32'd0);
        check("rst2_op_a", op_a, 32'h1);
        check("rst2_op_b", op_b, 32'h2);
        step(); step(); step();
        check("sb_drained", wb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
